// File: rtl/led_pattern_gen.sv
// LED pattern generator: blink, binary count, bouncing chase and PWM breathe,
// stepped by a programmable prescaler with pause control and a step strobe.
module led_pattern_gen #(
    parameter int TICK_DIV = 1500000,
    parameter int NUM_LEDS = 5,
    parameter int PWM_BITS = 8
) (
    input  logic                CLK_IN,
    input  logic                RST_IN,
    input  logic [1:0]          MODE_IN,
    input  logic                EN_IN,
    output logic [NUM_LEDS-1:0] LED_OUT,
    output logic                STEP_OUT
);

    typedef enum logic [1:0] {
        MODE_BLINK   = 2'd0,
        MODE_COUNT   = 2'd1,
        MODE_CHASE   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    localparam int SW = (NUM_LEDS > PWM_BITS) ? NUM_LEDS : PWM_BITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0]       PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]       PRESC_ONE = PW'(1);
    localparam logic [SW-1:0]       ST_ONE    = SW'(1);
    localparam logic [SW-1:0]       CHASE_END = SW'(NUM_LEDS - 1);
    localparam logic [SW-1:0]       LEVEL_MAX = SW'((1 << PWM_BITS) - 1);
    localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);
    localparam logic [NUM_LEDS-1:0] LED_ONE   = NUM_LEDS'(1);

    mode_t               r_mode_q;
    logic [PW-1:0]       r_presc;
    logic [SW-1:0]       r_state;
    logic                r_dir;      // 1 = moving up
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                r_tick_q;
    logic                r_step;
    logic [NUM_LEDS-1:0] r_led;

    logic                w_mode_chg;
    logic                w_tick;
    logic [SW-1:0]       w_state_nxt;
    logic                w_dir_nxt;
    logic [NUM_LEDS-1:0] w_pattern;

    assign w_mode_chg = (MODE_IN != r_mode_q);
    assign w_tick     = (r_presc == PRESC_MAX) && EN_IN && !w_mode_chg;

    // The single step register is reinterpreted per mode; chase and breathe bounce off their ends without dwelling.
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        case (r_mode_q)
            MODE_BLINK: w_state_nxt[0] = ~r_state[0];
            MODE_COUNT: w_state_nxt = r_state + ST_ONE;
            MODE_CHASE: begin
                if (NUM_LEDS > 1) begin
                    if (r_dir) begin
                        if (r_state == CHASE_END) begin
                            w_state_nxt = r_state - ST_ONE;
                            w_dir_nxt   = 1'b0;
                        end else begin
                            w_state_nxt = r_state + ST_ONE;
                        end
                    end else begin
                        if (r_state == '0) begin
                            w_state_nxt = ST_ONE;
                            w_dir_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = r_state - ST_ONE;
                        end
                    end
                end
            end
            default: begin
                if (r_dir) begin
                    if (r_state == LEVEL_MAX) begin
                        w_state_nxt = r_state - ST_ONE;
                        w_dir_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = r_state + ST_ONE;
                    end
                end else begin
                    if (r_state == '0) begin
                        w_state_nxt = ST_ONE;
                        w_dir_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = r_state - ST_ONE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        w_pattern = '0;
        case (r_mode_q)
            MODE_BLINK: w_pattern = {NUM_LEDS{r_state[0]}};
            MODE_COUNT: w_pattern = r_state[NUM_LEDS-1:0];
            MODE_CHASE: w_pattern = LED_ONE << r_state;
            default:    w_pattern = {NUM_LEDS{r_pwm_cnt < r_state[PWM_BITS-1:0]}};
        endcase
    end

    // State updates on the tick edge; LED_OUT and STEP_OUT follow one edge later so they stay aligned.
    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            r_mode_q  <= MODE_BLINK;
            r_presc   <= '0;
            r_state   <= '0;
            r_dir     <= 1'b1;
            r_pwm_cnt <= '0;
            r_tick_q  <= 1'b0;
            r_step    <= 1'b0;
            r_led     <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
            r_tick_q  <= w_tick;
            r_step    <= r_tick_q;
            r_led     <= w_pattern;
            if (w_mode_chg) begin
                r_mode_q <= mode_t'(MODE_IN);
                r_presc  <= '0;
                r_state  <= '0;
                r_dir    <= 1'b1;
            end else if (EN_IN) begin
                r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + PRESC_ONE;
                if (w_tick) begin
                    r_state <= w_state_nxt;
                    r_dir   <= w_dir_nxt;
                end
            end
        end
    end

    assign LED_OUT  = r_led;
    assign STEP_OUT = r_step;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with TICK_DIV=4, NUM_LEDS=4, PWM_BITS=3;
// expected patterns, step gaps and duty counts are worked out by hand.
module tb_led_pattern_gen;

    localparam int TD = 4;
    localparam int NL = 4;
    localparam int PB = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    mode;
    logic [NL-1:0] led;
    logic          stp;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .TICK_DIV (TD),
        .NUM_LEDS (NL),
        .PWM_BITS (PB)
    ) dut (
        .CLK_IN   (clk),
        .RST_IN   (rst),
        .MODE_IN  (mode),
        .EN_IN    (en),
        .LED_OUT  (led),
        .STEP_OUT (stp)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges until STEP_OUT is seen high, or -1 on timeout.
    task automatic wait_step(output int n);
        n = -1;
        for (int i = 1; i <= 64; i++) begin
            edge1();
            if (stp) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic expect_step(input string tag, input int gap, input logic [NL-1:0] pat);
        int n;
        wait_step(n);
        check_val({tag, "_gap"}, n, gap);
        check_val({tag, "_led"}, led, pat);
    endtask

    task automatic change_mode(input string tag, input logic [1:0] m, input logic [NL-1:0] pat0);
        mode = m;
        edge1();
        check_val({tag, "_stp_e1"}, stp, 1'b0);
        edge1();
        check_val({tag, "_stp_e2"}, stp, 1'b0);
        check_val({tag, "_step0"}, led, pat0);
    endtask

    // Freezes the step for 8 cycles and counts how many show all LEDs lit.
    task automatic measure_duty(input string tag, input int lvl);
        int on_cnt;
        int mixed;
        on_cnt = 0;
        mixed  = 0;
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) edge1();
            if (led == '1) on_cnt++;
            else if (led != '0) mixed++;
        end
        check_val({tag, "_duty"}, on_cnt, lvl);
        check_val({tag, "_uniform"}, mixed, 0);
        en = 1'b1;
    endtask

    initial begin
        int lv[16];
        int bad;
        lv = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

        rst  = 1'b1;
        mode = 2'd0;
        en   = 1'b1;

        for (int i = 0; i < 3; i++) begin
            edge1();
            check_val("rst_led", led, 4'b0000);
            check_val("rst_stp", stp, 1'b0);
        end
        rst = 1'b0;

        expect_step("blink_first", 5, 4'b1111);
        edge1();
        check_val("step_width", stp, 1'b0);
        expect_step("blink_off", 3, 4'b0000);
        expect_step("blink_on", 4, 4'b1111);

        change_mode("count", 2'd1, 4'b0000);
        for (int i = 1; i <= 17; i++)
            expect_step($sformatf("count%0d", i), 4, NL'(i % 16));

        change_mode("chase", 2'd2, 4'b0001);
        begin
            logic [NL-1:0] chase_exp [7];
            chase_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
            for (int i = 0; i < 7; i++)
                expect_step($sformatf("chase%0d", i), 4, chase_exp[i]);
        end

        change_mode("count2", 2'd1, 4'b0000);
        for (int i = 1; i <= 5; i++)
            expect_step($sformatf("count2_%0d", i), 4, NL'(i));
        en  = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            edge1();
            if (stp || led != 4'b0101) bad++;
        end
        check_val("pause_hold", bad, 0);
        check_val("pause_led", led, 4'b0101);
        change_mode("pause_chase", 2'd2, 4'b0001);
        en = 1'b1;
        expect_step("resume", 5, 4'b0010);

        change_mode("breathe", 2'd3, 4'b0000);
        measure_duty("lvl0", lv[0]);
        for (int k = 1; k < 16; k++) begin
            int n;
            wait_step(n);
            check_val($sformatf("breathe%0d_gap", k), n, 4);
            measure_duty($sformatf("breathe%0d", k), lv[k]);
        end
        for (int k = 2; k <= 5; k++) begin
            int n;
            wait_step(n);
            check_val($sformatf("to_lvl%0d_gap", k), n, 4);
        end

        rst  = 1'b1;
        mode = 2'd0;
        edge1();
        check_val("midrst_led", led, 4'b0000);
        check_val("midrst_stp", stp, 1'b0);
        check_val("midrst_mode", dut.r_mode_q, 2'd0);
        rst = 1'b0;
        expect_step("rst2_first", 5, 4'b1111);
        expect_step("rst2_second", 4, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
